// File: rtl/aes_pkg.sv
// Shared AES definitions for the SubBytes engine: byte type, FSM state
// encoding and the FIPS-197 forward/inverse S-box tables.
package aes_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sub_bytes_folded_if.sv
// Valid/ready stream interface of the folded SubBytes engine.
// slave is the engine side, master is the upstream/downstream side.
interface sub_bytes_folded_if #(
    parameter int DATA_W = 128
);
    logic              i_valid;
    logic              o_ready;
    logic              i_inv;
    logic [DATA_W-1:0] data_in;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] data_out;
    logic              o_busy;

    modport slave (
        input  i_valid, i_inv, data_in, i_ready,
        output o_ready, o_valid, data_out, o_busy
    );

    modport master (
        output i_valid, i_inv, data_in, i_ready,
        input  o_ready, o_valid, data_out, o_busy
    );
endinterface

// File: rtl/sbox_lane.sv
// One combinational S-box lane. The inverse table exists only when
// SUB_BYTES_INV_EN is defined; otherwise the mode input is ignored.
module sbox_lane
    import aes_pkg::*;
(
    input  byte_t byte_in,
    input  logic  inv,
    output byte_t byte_out
);

`ifdef SUB_BYTES_INV_EN
    // Table lookup, inverse or forward depending on the captured mode.
    always_comb begin
        byte_out = inv ? INV_SBOX[byte_in] : SBOX[byte_in];
    end
`else
    logic unused_inv;
    assign unused_inv = inv;

    // Forward-only lookup; the mode bit is dropped.
    always_comb begin
        byte_out = SBOX[byte_in];
    end
`endif

endmodule

// File: rtl/sub_bytes_folded.sv
// Folded SubBytes engine: LANES S-box lanes walk across a DATA_W-bit
// state over NBEATS beats. Inverse substitution is available when
// SUB_BYTES_INV_EN is defined.
module sub_bytes_folded
    import aes_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int LANES  = 4
) (
    input logic               clk,
    input logic               rst,
    sub_bytes_folded_if.slave bus
);

    localparam int NBYTES = DATA_W / 8;
    localparam int NBEATS = NBYTES / LANES;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int LANE_W = LANES * 8;

    if (((DATA_W % 8) != 0) || ((NBYTES % LANES) != 0)) begin : g_cfg_err
        $error("sub_bytes_folded: DATA_W must be a multiple of 8 and DATA_W/8 a multiple of LANES");
    end

    sub_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] word_reg;
    logic              inv_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic              accept;
    logic              ready;
    logic              last_beat;
    logic [LANE_W-1:0] beat_in;
    logic [LANE_W-1:0] beat_out;

    assign last_beat = (cnt_reg == CNT_W'(NBEATS - 1));

    // Slice of the captured word handled in the current beat.
    assign beat_in = word_reg[int'(cnt_reg) * LANE_W +: LANE_W];

    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : g_lane
        sbox_lane u_lane (
            .byte_in  (beat_in[gi*8 +: 8]),
            .inv      (inv_reg),
            .byte_out (beat_out[gi*8 +: 8])
        );
    end

    // Next-state and handshake decode; DONE can hand over straight to RUN.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        ready      = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (bus.i_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    ready = 1'b1;
                    if (bus.i_valid) begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture on accept, then write one lane-group of results per RUN beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            word_reg     <= '0;
            inv_reg      <= 1'b0;
            data_out_reg <= '0;
        end else if (accept) begin
            cnt_reg  <= '0;
            word_reg <= bus.data_in;
            inv_reg  <= bus.i_inv;
        end else if (state_reg == RUN) begin
            data_out_reg[int'(cnt_reg) * LANE_W +: LANE_W] <= beat_out;
            cnt_reg <= last_beat ? '0 : cnt_reg + 1'b1;
        end
    end

    assign bus.o_ready  = ready;
    assign bus.o_valid  = (state_reg == DONE);
    assign bus.o_busy   = (state_reg == RUN);
    assign bus.data_out = data_out_reg;

endmodule

// File: tb/tb_sub_bytes_folded.sv
// Self-checking bench for sub_bytes_folded: three instances (LANES 4, 16, 1)
// checked against an S-box model derived from GF(2^8) arithmetic.
module tb_sub_bytes_folded;

`ifdef SUB_BYTES_INV_EN
    localparam bit INV_ON = 1'b1;
`else
    localparam bit INV_ON = 1'b0;
`endif

    logic clk;
    logic rst;

    logic         i_valid  [3];
    logic         i_inv    [3];
    logic         i_ready  [3];
    logic [127:0] data_in  [3];
    logic         o_valid  [3];
    logic         o_ready  [3];
    logic         o_busy   [3];
    logic [127:0] data_out [3];

    int lat_exp [3] = '{5, 2, 17};

    int errors = 0;
    int checks = 0;

    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_dut
        sub_bytes_folded_if #(.DATA_W(128)) bus ();

        assign bus.i_valid  = i_valid[gi];
        assign bus.i_inv    = i_inv[gi];
        assign bus.i_ready  = i_ready[gi];
        assign bus.data_in  = data_in[gi];
        assign o_valid[gi]  = bus.o_valid;
        assign o_ready[gi]  = bus.o_ready;
        assign o_busy[gi]   = bus.o_busy;
        assign data_out[gi] = bus.data_out;

        sub_bytes_folded #(
            .DATA_W (128),
            .LANES  ((gi == 0) ? 4 : ((gi == 1) ? 16 : 1))
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] xi;
        xi = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) xi = 8'(y);
        end
        return xi ^ {xi[6:0], xi[7]} ^ {xi[5:0], xi[7:6]} ^ {xi[4:0], xi[7:5]}
                  ^ {xi[3:0], xi[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_word(input logic [127:0] d, input bit inv);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) begin
            r[8*b +: 8] = (inv && INV_ON) ? inv_t[d[8*b +: 8]] : fwd_t[d[8*b +: 8]];
        end
        return r;
    endfunction

    task automatic check(input bit ok, input string what,
                         input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, required %h", what, act, exp);
        end
    endtask

    // One word through instance n with i_ready held high; checks latency and result.
    task automatic run_word(input int n, input logic [127:0] d, input bit inv,
                            input logic [127:0] exp, input string tag);
        int lat;
        i_ready[n] = 1'b1;
        #1;
        check(o_ready[n] === 1'b1, $sformatf("%s inst%0d ready", tag, n), 128'(o_ready[n]), 128'd1);
        i_valid[n] = 1'b1;
        data_in[n] = d;
        i_inv[n]   = inv;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            i_valid[n] = 1'b0;
            if (o_valid[n] === 1'b1) begin
                lat = c;
                break;
            end
        end
        check(lat == lat_exp[n], $sformatf("%s inst%0d latency", tag, n), 128'(lat), 128'(lat_exp[n]));
        check(data_out[n] === exp, $sformatf("%s inst%0d data", tag, n), data_out[n], exp);
        $display("txn %s inst%0d: in=%h inv=%0d out=%h lat=%0d", tag, n, d, inv, data_out[n], lat);
    endtask

    // Random stream with random back-pressure; scoreboard of expected words.
    task automatic stream(input int n, input int words);
        logic [127:0] expq [$];
        logic [127:0] held;
        logic [127:0] want;
        bit           stalled;
        int           got;
        int           cyc;
        stalled = 1'b0;
        held    = '0;
        got     = 0;
        cyc     = 0;
        while (got < words && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check(o_valid[n] === 1'b1 && data_out[n] === held,
                      $sformatf("stream inst%0d hold", n), data_out[n], held);
            end
            i_ready[n] = ($urandom_range(0, 3) != 0);
            i_valid[n] = ($urandom_range(0, 4) != 0);
            data_in[n] = {$urandom, $urandom, $urandom, $urandom};
            i_inv[n]   = $urandom_range(0, 1) == 1;
            #1;
            if (o_valid[n] === 1'b1 && i_ready[n]) begin
                if (expq.size() == 0) begin
                    check(1'b0, $sformatf("stream inst%0d unexpected word", n), data_out[n], '0);
                end else begin
                    want = expq.pop_front();
                    check(data_out[n] === want, $sformatf("stream inst%0d word %0d", n, got),
                          data_out[n], want);
                end
                got++;
            end
            stalled = (o_valid[n] === 1'b1) && !i_ready[n];
            held    = data_out[n];
            if (i_valid[n] && o_ready[n] === 1'b1) begin
                expq.push_back(sub_word(data_in[n], i_inv[n]));
            end
        end
        check(got >= words, $sformatf("stream inst%0d completion", n), 128'(got), 128'(words));
        i_valid[n] = 1'b0;
        i_ready[n] = 1'b1;
    endtask

    typedef struct {
        logic [127:0] din;
        bit           inv;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs [6];
    logic [127:0] word_a;
    logic [127:0] want;
    int           lat;
    bit           quiet;

    initial begin
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            i_valid[n] = 1'b0;
            i_inv[n]   = 1'b0;
            i_ready[n] = 1'b1;
            data_in[n] = '0;
        end

        for (int i = 0; i < 256; i++) begin
            fwd_t[i] = sbox_calc(8'(i));
            inv_t[fwd_t[i]] = 8'(i);
        end

        vecs[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230};
        vecs[1] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b1,
                    INV_ON ? 128'h193de3bea0f4e22b9ac68d2ae9f84808
                           : sub_word(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0)};
        vecs[2] = '{128'h0, 1'b0, {16{8'h63}}};
        vecs[3] = '{{16{8'hff}}, 1'b0, {16{8'h16}}};
        vecs[4] = '{{16{8'h63}}, 1'b1, INV_ON ? 128'h0 : {16{8'hfb}}};
        vecs[5] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h637c777bf26b6fc53001672bfed7ab76};

        // Reset state.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            check(o_valid[n] === 1'b0, $sformatf("reset inst%0d o_valid", n), 128'(o_valid[n]), 128'd0);
            check(o_busy[n] === 1'b0, $sformatf("reset inst%0d o_busy", n), 128'(o_busy[n]), 128'd0);
            check(o_ready[n] === 1'b1, $sformatf("reset inst%0d o_ready", n), 128'(o_ready[n]), 128'd1);
            check(data_out[n] === 128'h0, $sformatf("reset inst%0d data_out", n), data_out[n], 128'h0);
        end

        // Table-driven known answers on every instance.
        for (int v = 0; v < 6; v++) begin
            for (int n = 0; n < 3; n++) begin
                run_word(n, vecs[v].din, vecs[v].inv, vecs[v].exp, $sformatf("vec%0d", v));
            end
        end

        // Back-pressure: hold the all-zero result for 10 cycles.
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            i_ready[n] = 1'b0;
            i_valid[n] = 1'b1;
            data_in[n] = '0;
            i_inv[n]   = 1'b0;
        end
        @(negedge clk);
        for (int n = 0; n < 3; n++) i_valid[n] = 1'b0;
        repeat (17) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int n = 0; n < 3; n++) begin
                check(o_valid[n] === 1'b1, $sformatf("bp inst%0d o_valid", n), 128'(o_valid[n]), 128'd1);
                check(o_ready[n] === 1'b0, $sformatf("bp inst%0d o_ready", n), 128'(o_ready[n]), 128'd0);
                check(data_out[n] === {16{8'h63}}, $sformatf("bp inst%0d data", n), data_out[n], {16{8'h63}});
            end
        end
        for (int n = 0; n < 3; n++) begin
            i_ready[n] = 1'b1;
            i_valid[n] = 1'b1;
            data_in[n] = {16{8'hff}};
        end
        #1;
        for (int n = 0; n < 3; n++) begin
            check(o_ready[n] === 1'b1, $sformatf("bp release inst%0d o_ready", n), 128'(o_ready[n]), 128'd1);
        end
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            i_valid[n] = 1'b0;
            check(o_busy[n] === 1'b1 && o_valid[n] === 1'b0, $sformatf("bp release inst%0d run", n),
                  128'({o_busy[n], o_valid[n]}), 128'b10);
        end
        repeat (18) @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            check(data_out[n] === {16{8'h16}}, $sformatf("bp next inst%0d data", n), data_out[n], {16{8'h16}});
        end
        $display("txn backpressure: held 10 cycles then handed over");

        // Mode/data capture: inputs churn during RUN with i_valid still high.
        word_a = 128'h00112233445566778899aabbccddeeff;
        for (int n = 0; n < 3; n++) begin
            for (int m = 0; m < 2; m++) begin
                want = sub_word(word_a, m == 1);
                @(negedge clk);
                i_ready[n] = 1'b1;
                i_valid[n] = 1'b1;
                data_in[n] = word_a;
                i_inv[n]   = (m == 1);
                lat = 0;
                for (int c = 1; c <= 40; c++) begin
                    @(negedge clk);
                    if (o_valid[n] === 1'b1) begin
                        i_valid[n] = 1'b0;
                        lat = c;
                        break;
                    end
                    data_in[n] = {$urandom, $urandom, $urandom, $urandom};
                    i_inv[n]   = ~i_inv[n];
                end
                check(lat == lat_exp[n], $sformatf("capture inst%0d mode%0d latency", n, m),
                      128'(lat), 128'(lat_exp[n]));
                check(data_out[n] === want, $sformatf("capture inst%0d mode%0d data", n, m),
                      data_out[n], want);
                $display("txn capture inst%0d mode%0d: out=%h lat=%0d", n, m, data_out[n], lat);
            end
        end

        // Reset two cycles after an accept discards the word.
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            i_valid[n] = 1'b1;
            i_ready[n] = 1'b1;
            data_in[n] = {16{8'hff}};
            i_inv[n]   = 1'b0;
        end
        @(negedge clk);
        for (int n = 0; n < 3; n++) i_valid[n] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            check(o_valid[n] === 1'b0 && o_busy[n] === 1'b0 && o_ready[n] === 1'b1,
                  $sformatf("midrun reset inst%0d flags", n),
                  128'({o_valid[n], o_busy[n], o_ready[n]}), 128'b001);
            check(data_out[n] === 128'h0, $sformatf("midrun reset inst%0d data", n), data_out[n], 128'h0);
        end
        for (int n = 0; n < 3; n++) begin
            quiet = 1'b1;
            for (int c = 0; c < 20; c++) begin
                #1;
                if (o_valid[n] !== 1'b0) quiet = 1'b0;
                if (n == 0) begin
                    @(negedge clk);
                end
            end
            check(quiet, $sformatf("midrun reset inst%0d no o_valid", n), 128'(quiet), 128'd1);
        end
        $display("txn midrun reset: word discarded");

        // Random streams, all three instances concurrently.
        repeat (3) @(negedge clk);
        fork
            stream(0, 1000);
            stream(1, 1000);
            stream(2, 1000);
        join
        $display("txn streams: 1000 words per instance");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
